data_mem_arbiter: RTL and testbench

- Shares the single-port data_mem between two requesters: the processor core (load/store path) and a host preload/readback port used to seed and dump operands around a program run.
- Performs round-robin arbitration, supports host burst lock with a core anti-starvation override, and registers the chosen command onto the memory pins.
- Drives a stall to the core so the PC/control path holds while a core access is pending.

---
 rtl/data_mem_arbiter_pkg.sv | 9 +
 rtl/data_mem_arbiter_if.sv | 47 ++++
 rtl/data_mem_arbiter_arb_rr_pick.sv | 30 +++
 rtl/data_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types for the data_mem arbiter
package data_mem_arb_pkg;

   typedef enum logic {ARB, ACCESS} state_t;
   typedef enum logic [1:0] {NONE, CORE, HOST} owner_t;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - core/host request ports and data_mem pins
interface data_mem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt;
   logic          c_rvalid;
   logic [DW-1:0] c_rdata;
   logic          c_stall;

   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   logic          h_lock;
   logic          h_gnt;
   logic          h_rvalid;
   logic [DW-1:0] h_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata, c_stall,
      input  h_req, h_we, h_addr, h_wdata, h_lock,
      output h_gnt, h_rvalid, h_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata, c_stall,
      output h_req, h_we, h_addr, h_wdata, h_lock,
      input  h_gnt, h_rvalid, h_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter_arb_rr_pick.sv
// rtl/data_mem_arbiter_arb_rr_pick.sv - round-robin winner selection
// A locked host keeps the memory only while the core has not starved.
module arb_rr_pick
   import data_mem_arb_pkg::*;
(
   input  logic   c_req,
   input  logic   h_req,
   input  logic   h_lock,
   input  owner_t last_win,
   input  logic   starve,
   output owner_t winner
);

   always_comb begin
      winner = NONE;
      if (c_req && h_req) begin
         if (last_win == HOST && h_lock && !starve)
            winner = HOST;
         else if (last_win == HOST)
            winner = CORE;
         else
            winner = HOST;
      end else if (c_req) begin
         winner = CORE;
      end else if (h_req) begin
         winner = HOST;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares single-port data_mem between core and host
// Two-cycle ARB/ACCESS sequence; the memory command is registered at the ARB edge.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic                CLK,
   input  logic                reset_n,
   data_mem_arbiter_if.slave   bus,
   output logic [15:0]         conflict_ct
);

   state_t            state_q;
   owner_t            owner_q;
   owner_t            last_win_q;
   owner_t            winner;
   logic [WAIT_W-1:0] wait_q;
   logic [15:0]       conflict_q;
   logic [AW-1:0]     mem_addr_q;
   logic [DW-1:0]     mem_wdata_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic              c_gnt_q;
   logic              h_gnt_q;
   logic              c_rvalid_q;
   logic              h_rvalid_q;
   logic [DW-1:0]     c_rdata_q;
   logic [DW-1:0]     h_rdata_q;
   logic              starve;
   logic              pick_host;

   assign starve    = (wait_q >= WAIT_W'(MAX_WAIT));
   assign pick_host = (winner == HOST);

   arb_rr_pick u_pick (
      .c_req    (bus.c_req),
      .h_req    (bus.h_req),
      .h_lock   (bus.h_lock),
      .last_win (last_win_q),
      .starve   (starve),
      .winner   (winner)
   );

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ARB;
         owner_q     <= NONE;
         last_win_q  <= HOST;
         wait_q      <= '0;
         conflict_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         c_gnt_q     <= 1'b0;
         h_gnt_q     <= 1'b0;
         c_rvalid_q  <= 1'b0;
         h_rvalid_q  <= 1'b0;
         c_rdata_q   <= '0;
         h_rdata_q   <= '0;
      end else begin
         c_rvalid_q <= 1'b0;
         h_rvalid_q <= 1'b0;

         if (c_gnt_q)
            wait_q <= '0;
         else if (bus.c_req && wait_q != {WAIT_W{1'b1}})
            wait_q <= wait_q + 1'b1;

         case (state_q)
            ARB: begin
               if (bus.c_req && bus.h_req && conflict_q != 16'hFFFF)
                  conflict_q <= conflict_q + 16'd1;
               if (winner != NONE) begin
                  mem_addr_q  <= pick_host ? bus.h_addr  : bus.c_addr;
                  mem_wdata_q <= pick_host ? bus.h_wdata : bus.c_wdata;
                  mem_we_q    <= pick_host ? bus.h_we    : bus.c_we;
                  mem_re_q    <= pick_host ? !bus.h_we   : !bus.c_we;
                  c_gnt_q     <= !pick_host;
                  h_gnt_q     <= pick_host;
                  owner_q     <= winner;
                  last_win_q  <= winner;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               // Read data is only trusted at the closing edge of the single access cycle.
               if (mem_re_q && owner_q == CORE) begin
                  c_rdata_q  <= bus.mem_rdata;
                  c_rvalid_q <= 1'b1;
               end
               if (mem_re_q && owner_q == HOST) begin
                  h_rdata_q  <= bus.mem_rdata;
                  h_rvalid_q <= 1'b1;
               end
               mem_we_q <= 1'b0;
               mem_re_q <= 1'b0;
               c_gnt_q  <= 1'b0;
               h_gnt_q  <= 1'b0;
               owner_q  <= NONE;
               state_q  <= ARB;
            end
            default: state_q <= ARB;
         endcase
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.c_gnt     = c_gnt_q;
   assign bus.h_gnt     = h_gnt_q;
   assign bus.c_rvalid  = c_rvalid_q;
   assign bus.h_rvalid  = h_rvalid_q;
   assign bus.c_rdata   = c_rdata_q;
   assign bus.h_rdata   = h_rdata_q;
   assign bus.c_stall   = (bus.c_req & ~c_gnt_q) | c_rvalid_q;
   assign conflict_ct   = conflict_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

   typedef struct {
      bit         side;   // 0 = core, 1 = host
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } acc_t;

   logic        clk;
   logic        reset_n;
   logic [15:0] conflict_ct;
   logic [7:0]  mem_arr [256];
   logic [7:0]  golden  [256];
   acc_t        exp_acc [$];
   logic [7:0]  exp_crd [$];
   logic [7:0]  exp_hrd [$];
   int          errors = 0;
   int          checks = 0;
   int          lat;
   bit          seen;

   data_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

   data_mem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
      .CLK         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .conflict_ct (conflict_ct)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   assign bus.mem_rdata = mem_arr[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      acc_t a;
      if (reset_n) begin
         if (bus.c_gnt || bus.h_gnt) begin
            check_eq("gnt_onehot", bus.c_gnt & bus.h_gnt, 0);
            check_eq("acc_expected", exp_acc.size() != 0, 1);
            if (exp_acc.size() != 0) begin
               a = exp_acc.pop_front();
               check_eq("gnt_side", bus.h_gnt, a.side);
               check_eq("mem_we", bus.mem_we, a.we);
               check_eq("mem_re", bus.mem_re, !a.we);
               check_eq("mem_addr", bus.mem_addr, a.addr);
               if (a.we) check_eq("mem_wdata", bus.mem_wdata, a.wdata);
            end
         end else begin
            check_eq("mem_idle", {bus.mem_we, bus.mem_re}, 0);
         end
         if (bus.c_rvalid) begin
            check_eq("crd_expected", exp_crd.size() != 0, 1);
            if (exp_crd.size() != 0) check_eq("c_rdata", bus.c_rdata, exp_crd.pop_front());
         end
         if (bus.h_rvalid) begin
            check_eq("hrd_expected", exp_hrd.size() != 0, 1);
            if (exp_hrd.size() != 0) check_eq("h_rdata", bus.h_rdata, exp_hrd.pop_front());
         end
      end
   end

   task automatic push_exp(input bit side, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
      acc_t a;
      a = '{side, we, addr, wdata};
      exp_acc.push_back(a);
      if (we) golden[addr] = wdata;
      else if (side) exp_hrd.push_back(golden[addr]);
      else exp_crd.push_back(golden[addr]);
   endtask

   task automatic do_access(input bit side, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, output int lat_o);
      push_exp(side, we, addr, wdata);
      @(posedge clk); #1;
      if (side) begin
         bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = addr; bus.h_wdata = wdata;
      end else begin
         bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
      end
      lat_o = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (side ? bus.h_gnt : bus.c_gnt) begin
            lat_o = i;
            break;
         end
      end
      check_eq(side ? "h_gnt_wait" : "c_gnt_wait", lat_o >= 0, 1);
      @(posedge clk); #1;
      if (side) bus.h_req = 1'b0; else bus.c_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'h00;
         golden[i]  = 8'h00;
      end
      reset_n = 1'b0;
      bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
      bus.h_req = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_wdata = 0; bus.h_lock = 0;

      // reset state
      repeat (2) @(negedge clk);
      check_eq("rst_gnt", {bus.c_gnt, bus.h_gnt}, 0);
      check_eq("rst_mem_cmd", {bus.mem_we, bus.mem_re}, 0);
      check_eq("rst_rvalid", {bus.c_rvalid, bus.h_rvalid}, 0);
      check_eq("rst_conflict", conflict_ct, 0);
      check_eq("rst_stall", bus.c_stall, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
      @(posedge clk); #1 reset_n = 1'b1;

      // core write then read of 8'h10, cycle-exact
      push_exp(0, 1, 8'h10, 8'hA5);
      @(posedge clk); #1;
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h10; bus.c_wdata = 8'hA5;
      @(negedge clk);
      check_eq("c_gnt_cyc0", bus.c_gnt, 0);
      check_eq("c_stall_cyc0", bus.c_stall, 1);
      @(negedge clk);
      check_eq("c_gnt_cyc1", bus.c_gnt, 1);
      check_eq("c_stall_gnt", bus.c_stall, 0);
      push_exp(0, 0, 8'h10, 8'h00);
      @(posedge clk); #1;
      bus.c_we = 0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rd_gnt_cyc1", bus.c_gnt, 1);
      @(posedge clk); #1 bus.c_req = 0;
      @(negedge clk);
      check_eq("rd_rvalid_cyc2", bus.c_rvalid, 1);
      check_eq("rd_stall_rvalid", bus.c_stall, 1);
      @(negedge clk);
      check_eq("rvalid_pulse", bus.c_rvalid, 0);
      check_eq("stall_after", bus.c_stall, 0);

      // seed operands for the tie test
      do_access(0, 1, 8'h01, 8'h3C, lat);
      check_eq("seed_c_lat", lat, 1);
      do_access(1, 1, 8'h02, 8'hC3, lat);
      check_eq("seed_h_lat", lat, 1);
      check_eq("no_conflict_yet", conflict_ct, 0);

      // continuous dual reads: C,H,C,H
      push_exp(0, 0, 8'h01, 0); push_exp(1, 0, 8'h02, 0);
      push_exp(0, 0, 8'h01, 0); push_exp(1, 0, 8'h02, 0);
      @(posedge clk); #1;
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h01;
      bus.h_req = 1; bus.h_we = 0; bus.h_addr = 8'h02;
      @(negedge clk);
      @(negedge clk);
      check_eq("tie_first_core", bus.c_gnt, 1);
      check_eq("conflict_first", conflict_ct, 1);
      repeat (7) @(posedge clk);
      #1 bus.c_req = 0; bus.h_req = 0;
      repeat (2) @(negedge clk);
      check_eq("conflict_tie", conflict_ct, 4);

      // idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_outs", {bus.c_gnt, bus.h_gnt, bus.mem_we, bus.mem_re,
                                bus.c_rvalid, bus.h_rvalid}, 0);
      end
      check_eq("idle_conflict", conflict_ct, 4);

      // host lock with core starvation override: H,H,C,H,H,C
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      push_exp(1, 1, 8'h41, 8'h4D); push_exp(1, 1, 8'h41, 8'h4D); push_exp(0, 1, 8'h40, 8'h4C);
      push_exp(1, 1, 8'h41, 8'h4D); push_exp(1, 1, 8'h41, 8'h4D); push_exp(0, 1, 8'h40, 8'h4C);
      @(posedge clk); #1;
      bus.h_lock = 1;
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h40; bus.c_wdata = 8'h4C;
      bus.h_req = 1; bus.h_we = 1; bus.h_addr = 8'h41; bus.h_wdata = 8'h4D;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!bus.c_gnt) check_eq("c_stall_wait", bus.c_stall, 1);
      end
      @(posedge clk); #1;
      bus.c_req = 0; bus.h_req = 0; bus.h_lock = 0;
      @(negedge clk);
      check_eq("conflict_lock", conflict_ct, 6);
      do_access(0, 0, 8'h40, 0, lat);
      do_access(1, 0, 8'h41, 0, lat);

      // reset during a host-write access
      do_access(0, 1, 8'h30, 8'h11, lat);
      exp_acc.push_back('{1'b1, 1'b1, 8'h30, 8'h77});
      @(posedge clk); #1;
      bus.h_req = 1; bus.h_we = 1; bus.h_addr = 8'h30; bus.h_wdata = 8'h77;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.h_gnt) begin
            seen = 1;
            break;
         end
      end
      check_eq("abort_gnt_seen", seen, 1);
      #1 reset_n = 1'b0; bus.h_req = 0;
      #1;
      check_eq("abort_mem_we", bus.mem_we, 0);
      check_eq("abort_h_gnt", bus.h_gnt, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check_eq("abort_conflict", conflict_ct, 0);
      do_access(0, 0, 8'h30, 0, lat);
      check_eq("abort_arb_lat", lat, 1);

      // inputs changed during ACCESS are ignored
      push_exp(0, 1, 8'h10, 8'h5A);
      @(posedge clk); #1;
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h10; bus.c_wdata = 8'h5A;
      @(posedge clk); #1;
      bus.c_addr = 8'h20; bus.c_wdata = 8'hFF;
      @(negedge clk);
      check_eq("chg_gnt", bus.c_gnt, 1);
      @(posedge clk); #1 bus.c_req = 0;
      @(negedge clk);
      do_access(0, 0, 8'h20, 0, lat);
      do_access(0, 0, 8'h10, 0, lat);

      repeat (3) @(negedge clk);
      check_eq("acc_q_empty", exp_acc.size(), 0);
      check_eq("crd_q_empty", exp_crd.size(), 0);
      check_eq("hrd_q_empty", exp_hrd.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
